// File: rtl/elevator_scheduler.sv
// Elevator request scheduler: keypad capture, SCAN direction choice,
// floor-to-floor travel timing and door dwell timing.
module elevator_scheduler #(
    parameter int unsigned FLOORS      = 8,
    parameter int unsigned FLOOR_TICKS = 50_000_000,
    parameter int unsigned DOOR_TICKS  = 100_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        BCD_input,
    output logic [3:0]        current_floor,
    output logic              moving_up,
    output logic              moving_down,
    output logic              door_open,
    output logic [FLOORS-1:0] pending,
    output logic              busy
);

    localparam int unsigned MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int unsigned CW        = $clog2(MAX_TICKS);
    localparam logic [CW-1:0] FLOOR_LOAD = CW'(FLOOR_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LOAD  = CW'(DOOR_TICKS - 1);
    localparam logic [3:0] CODE_DOOR  = 4'b1011;
    localparam logic [3:0] CODE_CLEAR = 4'b1101;
    localparam logic [3:0] TOP_FLOOR  = 4'(FLOORS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR
    } state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [3:0]        floor_q, floor_d;
    logic [FLOORS-1:0] pend_q, pend_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        prev_q;

    logic       key_evt, floor_evt, door_cmd, clear_cmd, same_floor_key;
    logic       door_enter;
    logic [3:0] door_floor, next_floor;

    function automatic logic req_at(input logic [FLOORS-1:0] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned k = 0; k < FLOORS; k++) begin
            if (4'(k + 1) == f) r = p[k];
        end
        return r;
    endfunction

    function automatic logic req_above(input logic [FLOORS-1:0] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned k = 0; k < FLOORS; k++) begin
            if (p[k] && (4'(k + 1) > f)) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic req_below(input logic [FLOORS-1:0] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned k = 0; k < FLOORS; k++) begin
            if (p[k] && (4'(k + 1) < f)) r = 1'b1;
        end
        return r;
    endfunction

    // A held code fires once; only a change to a nonzero code is an event.
    always_comb begin
        key_evt        = (BCD_input != '0) && (BCD_input != prev_q);
        floor_evt      = key_evt && (BCD_input <= TOP_FLOOR);
        door_cmd       = key_evt && (BCD_input == CODE_DOOR);
        clear_cmd      = key_evt && (BCD_input == CODE_CLEAR);
        same_floor_key = floor_evt && (BCD_input == floor_q);
        next_floor     = dir_q ? (floor_q + 4'd1) : (floor_q - 4'd1);
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        floor_d    = floor_q;
        cnt_d      = cnt_q;
        door_enter = 1'b0;
        door_floor = floor_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (door_cmd || req_at(pend_q, floor_q)) begin
                    state_d    = S_DOOR;
                    door_enter = 1'b1;
                    cnt_d      = DOOR_LOAD;
                end else if (req_above(pend_q, floor_q) &&
                             (dir_q || !req_below(pend_q, floor_q))) begin
                    dir_d   = 1'b1;
                    state_d = S_MOVE;
                    cnt_d   = FLOOR_LOAD;
                end else if (req_below(pend_q, floor_q)) begin
                    dir_d   = 1'b0;
                    state_d = S_MOVE;
                    cnt_d   = FLOOR_LOAD;
                end
            end
            S_MOVE: begin
                if (cnt_q == '0) begin
                    floor_d = next_floor;
                    cnt_d   = FLOOR_LOAD;
                    if (req_at(pend_q, next_floor)) begin
                        state_d    = S_DOOR;
                        door_enter = 1'b1;
                        door_floor = next_floor;
                        cnt_d      = DOOR_LOAD;
                    end else if (!(dir_q ? req_above(pend_q, next_floor)
                                         : req_below(pend_q, next_floor))) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DOOR: begin
                if (door_cmd || same_floor_key) begin
                    cnt_d = DOOR_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Opening the door at a floor services it, overriding a same-edge request.
    always_comb begin
        pend_d = pend_q;
        if (clear_cmd) begin
            pend_d = '0;
        end else if (floor_evt && !(state_q == S_DOOR && same_floor_key)) begin
            for (int unsigned k = 0; k < FLOORS; k++) begin
                if (4'(k + 1) == BCD_input) pend_d[k] = 1'b1;
            end
        end
        if (door_enter) begin
            for (int unsigned k = 0; k < FLOORS; k++) begin
                if (4'(k + 1) == door_floor) pend_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b1;
            floor_q <= 4'd1;
            pend_q  <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            floor_q <= floor_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            prev_q  <= BCD_input;
        end
    end

    assign current_floor = floor_q;
    assign moving_up     = (state_q == S_MOVE) && dir_q;
    assign moving_down   = (state_q == S_MOVE) && !dir_q;
    assign door_open     = (state_q == S_DOOR);
    assign pending       = pend_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler and motion sequencer for the elevator car. It captures floor requests and commands from the 4-bit keypad code `BCD_input` and holds them in a pending-request register. It picks the travel direction with a SCAN policy: keep going while requests lie ahead, reverse only when none remain. It times floor-to-floor travel and door dwell, and drives the car status outputs consumed by the display and motor logic inside `management`.

## Interface
- `FLOORS`, default 8: number of floors, numbered 1..FLOORS; legal range 2..9.
- `FLOOR_TICKS`, default 50_000_000: CLK cycles per one-floor move; must be ≥ 2.
- `DOOR_TICKS`, default 100_000_000: CLK cycles the door stays open per dwell; must be ≥ 2.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `BCD_input`  in  4  keypad code; synchronous to `CLK`.
  - 4'b0000: no key.
  - 1..FLOORS: request that floor.
  - 4'b1011: door-open command.
  - 4'b1101: clear all pending requests.
  - Any other value: ignored.
- `current_floor`  out  4  floor the car is at, or last passed; binary 1..FLOORS.
- `moving_up`  out  1  car is in a MOVE toward a higher floor.
- `moving_down`  out  1  car is in a MOVE toward a lower floor.
- `door_open`  out  1  high exactly while the FSM is in DOOR.
- `pending`  out  FLOORS  bit k-1 set means floor k is requested.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- **Key capture.** A key event occurs on any edge where `BCD_input` is nonzero and differs from its value sampled on the previous edge (`prev_code` register).
  - A held code produces one event only.
  - A direct change of one nonzero code to another produces a new event.
  - Floor event for floor k sets `pending[k-1]` on that edge, with one exception: k == `current_floor` while in DOOR. That case restarts the door timer and does not set the bit.
  - 4'b1101 clears all `pending` bits on that edge.
  - 4'b1011 restarts the door timer when in DOOR, or enters DOOR when in IDLE. It is ignored in MOVE.
- **Direction register** `dir` (up/down); reset value is up.
- **FSM states:** IDLE, MOVE, DOOR.
- **IDLE**, evaluated on registered `pending`:
  - Bit for `current_floor` set: go to DOOR.
  - Else a request above exists and (`dir` is up, or no request below): set `dir` up and go to MOVE.
  - Else a request below exists: set `dir` down and go to MOVE.
  - Else stay in IDLE.
- **MOVE:** a travel counter counts FLOOR_TICKS cycles. On terminal count, `current_floor` steps ±1 per `dir` and the counter reloads. Then, evaluated against the new floor:
  - Bit for the new floor set: go to DOOR.
  - Else a request remains ahead in `dir`: stay in MOVE.
  - Else go to IDLE.
  - A clear-all during MOVE does not abort travel. The car completes the current floor step, then goes to IDLE.
- **DOOR:**
  - On entry, clear the `pending` bit for `current_floor` and load the dwell counter with DOOR_TICKS.
  - On terminal count, go to IDLE.
  - A restart from a same-floor request or 4'b1011 reloads the dwell counter to DOOR_TICKS.
- **Floor limits:** `current_floor` never leaves 1..FLOORS. MOVE is entered only when a request lies strictly ahead, so the car never moves up at FLOORS or down at 1.
- **Reset mid-operation:** immediately abandons travel and dwell.

## Timing
- **Reset values:**
  - `current_floor` = 1, `pending` = 0.
  - `moving_up` = `moving_down` = `door_open` = `busy` = 0.
  - State = IDLE, `dir` = up, counters = 0, `prev_code` = 0.
- **Request latency:** code applied before edge N sets `pending` at edge N. The IDLE decision uses it at edge N+1, so `busy`/`moving_*`/`door_open` assert after edge N+1.
- **Move duration:** a one-floor move lasts exactly FLOOR_TICKS cycles from MOVE entry to the `current_floor` update. A multi-floor move updates `current_floor` every FLOOR_TICKS cycles with no idle gap.
- **Door dwell:** `door_open` is high exactly DOOR_TICKS cycles per dwell, unless restarted. The cycle after it drops, the FSM is in IDLE and may start the next move at the following edge.
- **Output decoding:** all outputs are registered or decoded from registered state only; no combinational path from `BCD_input`.

## Test plan
Bench parameters: FLOORS=8, FLOOR_TICKS=4, DOOR_TICKS=3.
- Reset: pulse RST mid-MOVE from floor 1 toward 5 → all outputs return to reset values asynchronously; `current_floor`=1 and `pending`=0 after release.
- Single request: press 4'b0011 from floor 1.
  - `pending`=8'b00000100 one edge later.
  - `moving_up`=1; `current_floor`=2 then 3, 4 cycles apart.
  - `door_open`=1 for 3 cycles, then `pending`=0 and IDLE.
- SCAN order: at floor 4 going up with floors 6 and 2 pending, press 4'b1000 → stops at 6 then 8 (doors each), then reverses and stops at 2.
- Key edges:
  - Hold 4'b0101 for 10 cycles → one event only.
  - 4'b0001→4'b1101 directly → clear-all event taken.
  - 4'b1111 → ignored.
- Door control: in DOOR at floor 3, press 4'b1011, then 4'b0011 → each reloads dwell; `pending[2]` stays 0; `door_open` lasts 3 cycles after the last press.
- Clear-all in transit: MOVE 1→6, press 4'b1101 after 2 cycles → car arrives at floor 2, enters IDLE, no door; `busy`=0.
